// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control, preset and display signals of the BCD countdown timer
interface countdown_timer_if;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] load_min;
    logic [3:0] load_sec_l;
    logic [3:0] load_sec_r;
    logic [3:0] load_dsec;
    logic [3:0] Minutes;
    logic [3:0] Second_L;
    logic [3:0] Second_R;
    logic [3:0] Decisecond;
    logic       running;
    logic       expired;
    logic       done;

    modport master (
        output load, start, pause, load_min, load_sec_l, load_sec_r, load_dsec,
        input  Minutes, Second_L, Second_R, Decisecond, running, expired, done
    );

    modport slave (
        input  load, start, pause, load_min, load_sec_l, load_sec_r, load_dsec,
        output Minutes, Second_L, Second_R, Decisecond, running, expired, done
    );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - BCD M:SS.d countdown timer, max 9:59.9
// Optional feature: COUNTDOWN_AUTO_RELOAD_EN reloads the last preset on expiry while start is held.
module countdown_timer #(
    parameter int CLK_DIV = 10
) (
    input  logic              clk,
    input  logic              clr,
    countdown_timer_if.slave  tmr
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] m;
        logic [3:0] sl;
        logic [3:0] sr;
        logic [3:0] d;
    } bcd_t;

    state_t        state_q, state_d;
    bcd_t          val_q, val_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          running_q, expired_q;

    bcd_t load_val;
    bcd_t dec_val;
    logic val_zero;
    logic dec_zero;
    logic tick;

    function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
        return (v > mx) ? mx : v;
    endfunction

    // One-decisecond BCD borrow chain; seconds-tens wraps to 5, not 9.
    function automatic bcd_t bcd_dec(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.d != 4'd0) begin
            r.d = v.d - 4'd1;
        end else begin
            r.d = 4'd9;
            if (v.sr != 4'd0) begin
                r.sr = v.sr - 4'd1;
            end else begin
                r.sr = 4'd9;
                if (v.sl != 4'd0) begin
                    r.sl = v.sl - 4'd1;
                end else begin
                    r.sl = 4'd5;
                    r.m  = v.m - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign load_val.m  = clamp(tmr.load_min,   4'd9);
    assign load_val.sl = clamp(tmr.load_sec_l, 4'd5);
    assign load_val.sr = clamp(tmr.load_sec_r, 4'd9);
    assign load_val.d  = clamp(tmr.load_dsec,  4'd9);

    assign dec_val  = bcd_dec(val_q);
    assign val_zero = (val_q == '0);
    assign dec_zero = (dec_val == '0);
    assign tick     = (presc_q == PRESC_LAST);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    bcd_t preset_q, preset_d;
`endif

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        presc_d = presc_q;
        done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        preset_d = preset_q;
`endif

        if (tmr.load) begin
            val_d   = load_val;
            state_d = IDLE;
            presc_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            preset_d = load_val;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tmr.pause && tmr.start) begin
                        state_d = PAUSE;
                    end else if (tmr.start) begin
                        if (val_zero) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (tmr.pause) begin
                        state_d = PAUSE;
                    end else if (tick && !val_zero) begin
                        presc_d = '0;
                        val_d   = dec_val;
                        if (dec_zero) begin
                            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (tmr.start && (preset_q != '0)) begin
                                val_d = preset_q;
                            end else begin
                                state_d = EXPIRED;
                            end
`else
                            state_d = EXPIRED;
`endif
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                PAUSE: begin
                    // Prescaler is left untouched so the resumed tick keeps its phase.
                    if (!tmr.pause && tmr.start) begin
                        if (val_zero) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                EXPIRED: begin
                    val_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            val_q     <= '0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            running_q <= (state_d == RUN);
            expired_q <= (state_d == EXPIRED);
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            preset_q <= '0;
        end else begin
            preset_q <= preset_d;
        end
    end
`endif

    assign tmr.Minutes    = val_q.m;
    assign tmr.Second_L   = val_q.sl;
    assign tmr.Second_R   = val_q.sr;
    assign tmr.Decisecond = val_q.d;
    assign tmr.running    = running_q;
    assign tmr.expired    = expired_q;
    assign tmr.done       = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed and random checks of countdown_timer against a deciseconds model
module tb_countdown_timer;

    localparam int CLK_DIV = 10;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP   = 3;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    countdown_timer_if ifc ();
    countdown_timer #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .clr(clr), .tmr(ifc));

    int n_cmp = 0;
    int n_bad = 0;

    // Model keeps the time as a plain count of deciseconds.
    int m_total  = 0;
    int m_preset = 0;
    int m_mode   = M_IDLE;
    int m_phase  = 0;
    bit m_done   = 1'b0;

    function automatic int lim(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int load_total();
        return lim(int'(ifc.load_min), 9) * 600 + lim(int'(ifc.load_sec_l), 5) * 100
             + lim(int'(ifc.load_sec_r), 9) * 10 + lim(int'(ifc.load_dsec), 9);
    endfunction

    function automatic logic [15:0] to_bcd(input int t);
        logic [3:0] a, b, c, d;
        a = 4'(t / 600);
        b = 4'((t % 600) / 100);
        c = 4'((t % 100) / 10);
        d = 4'(t % 10);
        return {a, b, c, d};
    endfunction

    function automatic logic [15:0] shown();
        return {ifc.Minutes, ifc.Second_L, ifc.Second_R, ifc.Decisecond};
    endfunction

    task automatic model_step();
        m_done = 1'b0;
        if (clr) begin
            m_total = 0; m_mode = M_IDLE; m_phase = 0;
        end else if (ifc.load) begin
            m_total = load_total(); m_preset = m_total; m_mode = M_IDLE; m_phase = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (ifc.pause && ifc.start) m_mode = M_PAUSE;
                    else if (ifc.start) begin
                        m_mode = (m_total == 0) ? M_EXP : M_RUN;
                        m_done = (m_total == 0);
                    end
                end
                M_RUN: begin
                    if (ifc.pause) m_mode = M_PAUSE;
                    else if (m_phase == CLK_DIV - 1) begin
                        m_phase = 0;
                        m_total = m_total - 1;
                        if (m_total == 0) begin
                            m_done = 1'b1;
                            if (AUTO_RELOAD && ifc.start && m_preset != 0) m_total = m_preset;
                            else m_mode = M_EXP;
                        end
                    end else m_phase = m_phase + 1;
                end
                M_PAUSE: begin
                    if (!ifc.pause && ifc.start) begin
                        m_mode = (m_total == 0) ? M_EXP : M_RUN;
                        m_done = (m_total == 0);
                    end
                end
                default: m_total = 0;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("digits",  {16'h0, shown()}, {16'h0, to_bcd(m_total)});
        chk("running", {31'h0, ifc.running}, {31'h0, m_mode == M_RUN});
        chk("expired", {31'h0, ifc.expired}, {31'h0, m_mode == M_EXP});
        chk("done",    {31'h0, ifc.done}, {31'h0, m_done});
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_preset(input int mn, input int sl, input int sr, input int ds);
        ifc.load_min   = 4'(mn);
        ifc.load_sec_l = 4'(sl);
        ifc.load_sec_r = 4'(sr);
        ifc.load_dsec  = 4'(ds);
    endtask

    task automatic do_load(input int mn, input int sl, input int sr, input int ds);
        set_preset(mn, sl, sr, ds);
        ifc.load = 1'b1;
        cyc();
        ifc.load = 1'b0;
    endtask

    int done_at, n_done, n_exp, n_wait;

    initial begin
        clr = 1'b1;
        ifc.load = 1'b0; ifc.start = 1'b0; ifc.pause = 1'b0;
        set_preset(0, 0, 0, 0);
        cyc(); cyc();
        chk("reset_digits", {16'h0, shown()}, 32'h0);
        clr = 1'b0;

        // 0:00.3 expires 30 cycles after entering RUN
        do_load(0, 0, 0, 3);
        ifc.start = 1'b1;
        cyc();
        done_at = -1; n_done = 0;
        for (int i = 1; i <= 35; i++) begin
            cyc();
            if (ifc.done) begin n_done++; done_at = i; end
        end
        chk("done_cycle", done_at, 30);
        chk("done_count", n_done, 1);
        chk("expired_hold", {31'h0, ifc.expired}, 32'h1);
        ifc.start = 1'b0;

        do_load(1, 0, 0, 0);
        ifc.start = 1'b1;
        repeat (11) cyc();
        chk("borrow_1m", {16'h0, shown()}, 32'h0599);
        do_load(0, 1, 0, 0);
        repeat (11) cyc();
        chk("borrow_10s", {16'h0, shown()}, 32'h0099);

        // pause mid-period, resume keeps prescaler phase
        do_load(9, 5, 9, 9);
        repeat (54) cyc();
        ifc.pause = 1'b1;
        repeat (50) cyc();
        chk("pause_hold", {16'h0, shown()}, 32'h9594);
        chk("pause_running", {31'h0, ifc.running}, 32'h0);
        ifc.pause = 1'b0;
        cyc();
        n_wait = 0;
        while (n_wait < 20 && shown() == 16'h9594) begin
            cyc();
            n_wait++;
        end
        chk("resume_latency", n_wait, 7);
        ifc.start = 1'b0;

        do_load(3, 7, 4, 12);
        chk("clamp_a", {16'h0, shown()}, 32'h3549);
        do_load(15, 5, 10, 9);
        chk("clamp_b", {16'h0, shown()}, 32'h9599);

        do_load(0, 0, 0, 0);
        ifc.start = 1'b1;
        cyc();
        chk("zero_expired", {31'h0, ifc.expired}, 32'h1);
        chk("zero_done", {31'h0, ifc.done}, 32'h1);
        cyc();
        chk("zero_done_once", {31'h0, ifc.done}, 32'h0);

        // clr beats a simultaneous load; then load alone mid-run
        do_load(0, 0, 5, 5);
        repeat (31) cyc();
        chk("mid_run", {16'h0, shown()}, 32'h0052);
        set_preset(2, 3, 0, 0);
        ifc.load = 1'b1; clr = 1'b1;
        cyc();
        ifc.load = 1'b0; clr = 1'b0;
        chk("clr_wins", {16'h0, shown()}, 32'h0);
        do_load(0, 0, 5, 5);
        repeat (31) cyc();
        do_load(2, 3, 0, 0);
        chk("load_mid_run", {16'h0, shown()}, 32'h2300);
        chk("load_idle", {31'h0, ifc.running}, 32'h0);
        ifc.start = 1'b0;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        do_load(0, 0, 0, 2);
        ifc.start = 1'b1;
        cyc();
        n_done = 0; n_exp = 0;
        repeat (60) begin
            cyc();
            n_done += int'(ifc.done);
            n_exp  += int'(ifc.expired);
        end
        chk("reload_done", n_done, 3);
        chk("reload_noexp", n_exp, 0);
        ifc.start = 1'b0;
`endif

        // random stimulus against the model
        repeat (800) begin
            clr       = ($urandom_range(0, 63) == 0);
            ifc.load  = ($urandom_range(0, 15) == 0);
            ifc.start = ($urandom_range(0, 3) != 0);
            ifc.pause = ($urandom_range(0, 5) == 0);
            set_preset(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0,
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- BCD countdown timer (M:SS.d, max 9:59.9): the down-counting counterpart of the team's 10-minute up-counting stopwatch.
- Loaded with a preset, decrements one decisecond per prescaler tick, flags expiry at 0:00.0.
- Drives the same four BCD digit outputs as the stopwatch, so display logic is shared.

Parameters:
- CLK_DIV, 10, clk cycles per decisecond tick. Bench uses 10; board build overrides to 10_000_000 for 100 MHz.
- PW, 4, prescaler width is $clog2(CLK_DIV); listed for reference only, derived internally, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, synchronous, active-high.
- load  in  1  one-cycle strobe; captures load_* digits.
- start  in  1  level; begin or resume counting.
- pause  in  1  level; hold count.
- load_min  in  4  preset minutes, BCD.
- load_sec_l  in  4  preset tens of seconds, BCD.
- load_sec_r  in  4  preset units of seconds, BCD.
- load_dsec  in  4  preset deciseconds, BCD.
- Minutes  out  4  current minutes digit.
- Second_L  out  4  current tens-of-seconds digit.
- Second_R  out  4  current units-of-seconds digit.
- Decisecond  out  4  current decisecond digit.
- running  out  1  high in RUN state.
- expired  out  1  high in EXPIRED state.
- done  out  1  one-cycle pulse on entry to EXPIRED.

Behaviour:
- Single clock domain. clr is sampled on the rising edge of clk only (synchronous, active-high).
- While clr is high: all digits 0, state IDLE, prescaler 0, running/expired/done 0.
- States:
  - IDLE: holds the loaded value. If start=1 and value≠0, go to RUN. If start=1 and value=0, go to EXPIRED.
  - RUN: prescaler counts 0..CLK_DIV-1. Tick fires on the cycle the prescaler equals CLK_DIV-1; the prescaler then wraps to 0. Each tick decrements the value by 0.1 s. If the tick takes the value to 0:00.0, go to EXPIRED in the same edge. pause=1 goes to PAUSE.
  - PAUSE: prescaler and digits frozen. pause=0 with start=1 returns to RUN; the prescaler resumes from its held value.
  - EXPIRED: digits stay 0:00.0 and expired=1 until load or clr.
- Priority each edge: clr > load > pause > start.
- load in any state:
  - digits take the load_* values; state goes to IDLE; prescaler clears.
  - Clamping: load_sec_l > 5 is clamped to 5; any other digit > 9 is clamped to 9.
  - Load mid-RUN discards the current count.
- Decrement is a BCD borrow chain:
  - Decisecond 0 → 9, with borrow.
  - Second_R 0 → 9, with borrow.
  - Second_L 0 → 5, with borrow.
  - Minutes decrements.
  - A tick is never applied when the value is already 0.
- Digit outputs and running/expired are registered; they update on the same edge as the state/tick.
- done asserts on the edge entering EXPIRED and is high for exactly one cycle. No retrigger while in EXPIRED.
- start and pause both high: pause wins; state stays in or enters PAUSE.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - On reaching 0:00.0 the timer still pulses done.
  - In the same edge, digits reload from a preset register captured at the last load.
  - State stays RUN; expired never asserts while start is held.
  - If the preset is 0, the timer goes to EXPIRED as normal.
- Undefined: no preset register is kept; behaviour is as described above.

Test Plan:
- clr=1 for 2 cycles → digits 0:00.0, running=0, expired=0, done=0. Then load 0:00.3, start=1 (CLK_DIV=10) → ticks at cycles 10, 20, 30 after RUN entry; done high exactly one cycle coincident with 0:00.0; expired=1 thereafter.
- Load 1:00.0, run one tick → 0:59.9. Load 0:10.0, one tick → 0:09.9 (checks the full borrow chain).
- Load 9:59.9, run 5 ticks, pause 50 cycles → digits hold 9:59.4. Release pause → next tick arrives after the remaining prescaler count, not a full period.
- Load with load_sec_l=7, load_dsec=12 → Second_L=5, Decisecond=9. Load 0:00.0 then start → expired next edge, done one pulse.
- Mid-RUN at 0:05.2, assert load (2:30.0) and clr on the same edge → clr wins, digits 0:00.0. Repeat with load only → 2:30.0, IDLE, running=0.
- With COUNTDOWN_AUTO_RELOAD_EN defined: load 0:00.2, start → done pulses every 20 cycles, digits cycle 0:00.2 → 0:00.1 → 0:00.2 …, expired stays 0.
